// File: rtl/instr_decode_unit.sv
// Instruction decode unit: accepts instruction words over a valid/ready handshake and
// produces registered load/store/register-enable strobes, with core reset sequencing and RAW stall.
package instr_decode_pkg;
  localparam logic [3:0] OP_RST = 4'h0;
  localparam logic [3:0] OP_LD  = 4'h1;
  localparam logic [3:0] OP_ST  = 4'h2;
endpackage

module instr_decode_unit
  import instr_decode_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int NREGS        = 4,
  parameter int RST_LEN      = 4,
  parameter int HAZARD_STALL = 1,
  localparam int INSTR_W     = NREGS + 4 + DATA_W
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] cell_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               core_rstn,
  output logic               load_en,
  output logic               store_en,
  output logic [NREGS-1:0]   reg_ce,
  output logic [NREGS-1:0]   reg_oe,
  output logic [3:0]         instr_code,
  output logic [DATA_W-1:0]  imm,
  output logic               illegal,
  output logic               err_sticky
);

  typedef enum logic [1:0] {RUN, RST_HOLD, STALL} state_t;

  state_t            state;
  logic [7:0]        rst_cnt;
  logic [NREGS-1:0]  last_wr_mask;

  logic [NREGS-1:0]  in_mask;
  logic [3:0]        in_op;
  logic [DATA_W-1:0] in_imm;
  logic              is_rst, is_ld, is_st, is_alu;
  logic              multi_hot;
  logic              hazard;
  logic              transfer;

  assign in_mask = cell_data[INSTR_W-1:DATA_W+4];
  assign in_op   = cell_data[DATA_W+3:DATA_W];
  assign in_imm  = cell_data[DATA_W-1:0];

  assign is_rst = (in_op == OP_RST);
  assign is_ld  = (in_op == OP_LD);
  assign is_st  = (in_op == OP_ST);
  assign is_alu = !(is_rst || is_ld || is_st);

  // Clearing the lowest set bit leaves something only when two or more bits were set.
  assign multi_hot = |(in_mask & (in_mask - NREGS'(1)));

  assign hazard   = (HAZARD_STALL != 0) && in_valid && (state == RUN) && is_alu &&
                    (|(in_mask & last_wr_mask));
  assign in_ready = (state == RUN) && (!out_valid || out_ready) && !hazard;
  assign transfer = in_valid && in_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order inside the block.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= RUN;
      rst_cnt      <= '0;
      last_wr_mask <= '0;
      core_rstn    <= 1'b0;
      out_valid    <= 1'b0;
      load_en      <= 1'b0;
      store_en     <= 1'b0;
      reg_ce       <= '0;
      reg_oe       <= '0;
      instr_code   <= '0;
      imm          <= '0;
      illegal      <= 1'b0;
      err_sticky   <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          core_rstn <= 1'b1;
          if (hazard) begin
            state        <= STALL;
            last_wr_mask <= '0;
          end else if (transfer && is_rst) begin
            state        <= RST_HOLD;
            core_rstn    <= 1'b0;
            rst_cnt      <= '0;
            last_wr_mask <= '0;
          end
        end
        RST_HOLD: begin
          if (rst_cnt == 8'(RST_LEN - 1)) begin
            state     <= RUN;
            core_rstn <= 1'b1;
            rst_cnt   <= '0;
          end else begin
            rst_cnt <= rst_cnt + 8'd1;
          end
        end
        STALL: begin
          state     <= RUN;
          core_rstn <= 1'b1;
        end
        default: state <= RUN;
      endcase

      // Output slot: loads only on a non-RST transfer, otherwise drains when consumed.
      if (transfer && !is_rst) begin
        out_valid  <= 1'b1;
        instr_code <= in_op;
        imm        <= in_imm;
        load_en    <= is_ld;
        store_en   <= is_st;
        illegal    <= is_alu && multi_hot;
        reg_ce     <= (is_ld || is_st) ? in_mask : '0;
        reg_oe     <= (is_alu && !multi_hot) ? in_mask : '0;
        if (is_ld || is_st) last_wr_mask <= in_mask;
        if (is_alu && multi_hot) err_sticky <= 1'b1;
      end else if (transfer && is_rst) begin
        out_valid <= 1'b0;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_decode_unit.sv
// Scoreboard bench for instr_decode_unit: a behavioural model predicts handshake, core reset
// and decoded beats; a separate monitor compares each presented beat against the queue.
module tb_instr_decode_unit;
  import instr_decode_pkg::*;

  localparam int DATA_W  = 8;
  localparam int NREGS   = 4;
  localparam int RST_LEN = 4;
  localparam int INSTR_W = NREGS + 4 + DATA_W;

  logic               clk = 1'b0;
  logic               rstn = 1'b0;
  logic               in_valid = 1'b0;
  logic               out_ready = 1'b0;
  logic [INSTR_W-1:0] cell_data = '0;

  logic               in_ready, out_valid, core_rstn, load_en, store_en, illegal, err_sticky;
  logic [NREGS-1:0]   reg_ce, reg_oe;
  logic [3:0]         instr_code;
  logic [DATA_W-1:0]  imm;

  logic               nh_in_ready, nh_out_valid, nh_core_rstn, nh_load_en, nh_store_en;
  logic               nh_illegal, nh_err_sticky;
  logic [NREGS-1:0]   nh_reg_ce, nh_reg_oe;
  logic [3:0]         nh_instr_code;
  logic [DATA_W-1:0]  nh_imm;

  instr_decode_unit #(.DATA_W(DATA_W), .NREGS(NREGS), .RST_LEN(RST_LEN), .HAZARD_STALL(1)) u_dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .cell_data(cell_data),
    .out_valid(out_valid), .out_ready(out_ready), .core_rstn(core_rstn), .load_en(load_en),
    .store_en(store_en), .reg_ce(reg_ce), .reg_oe(reg_oe), .instr_code(instr_code), .imm(imm),
    .illegal(illegal), .err_sticky(err_sticky)
  );

  instr_decode_unit #(.DATA_W(DATA_W), .NREGS(NREGS), .RST_LEN(RST_LEN), .HAZARD_STALL(0)) u_nh (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(nh_in_ready), .cell_data(cell_data),
    .out_valid(nh_out_valid), .out_ready(out_ready), .core_rstn(nh_core_rstn), .load_en(nh_load_en),
    .store_en(nh_store_en), .reg_ce(nh_reg_ce), .reg_oe(nh_reg_oe), .instr_code(nh_instr_code),
    .imm(nh_imm), .illegal(nh_illegal), .err_sticky(nh_err_sticky)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              load;
    logic              store;
    logic [NREGS-1:0]  ce;
    logic [NREGS-1:0]  oe;
    logic [3:0]        code;
    logic [DATA_W-1:0] imm;
    logic              ill;
  } beat_t;

  beat_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Behavioural model state: cycles of core reset still owed, pending stall bubble, last written mask.
  int               hold_left;
  int               stall_left;
  logic [NREGS-1:0] last_wr;
  bit               out_pending;
  bit               sticky;
  bit               fresh;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [INSTR_W-1:0] mk(input logic [3:0] op, input logic [NREGS-1:0] m,
                                            input logic [DATA_W-1:0] i);
    return {m, op, i};
  endfunction

  function automatic beat_t expect_beat(input logic [INSTR_W-1:0] w);
    beat_t b;
    logic [3:0] op;
    logic [NREGS-1:0] m;
    op = w[DATA_W+3:DATA_W];
    m  = w[INSTR_W-1:DATA_W+4];
    b = '0;
    b.code = op;
    b.imm  = w[DATA_W-1:0];
    if (op == OP_LD) begin
      b.load = 1'b1;
      b.ce   = m;
    end else if (op == OP_ST) begin
      b.store = 1'b1;
      b.ce    = m;
    end else if ($countones(m) > 1) begin
      b.ill = 1'b1;
    end else begin
      b.oe = m;
    end
    return b;
  endfunction

  task automatic model_reset();
    hold_left   = 0;
    stall_left  = 0;
    last_wr     = '0;
    out_pending = 1'b0;
    sticky      = 1'b0;
    fresh       = 1'b1;
    exp_q.delete();
  endtask

  task automatic check_reset_values();
    check("reset_outputs",
          {out_valid, core_rstn, load_en, store_en, reg_ce, reg_oe, instr_code, imm, illegal, err_sticky},
          '0);
  endtask

  // Called just after a rising edge; drives one cycle of inputs and advances the model.
  task automatic step(input logic v, input logic [INSTR_W-1:0] w, input logic ordy);
    logic [3:0] op;
    logic [NREGS-1:0] m;
    bit run, alu, haz, rdy, xfer;
    in_valid  = v;
    cell_data = w;
    out_ready = ordy;
    @(negedge clk);
    op   = w[DATA_W+3:DATA_W];
    m    = w[INSTR_W-1:DATA_W+4];
    run  = (hold_left == 0) && (stall_left == 0);
    alu  = (op != OP_RST) && (op != OP_LD) && (op != OP_ST);
    haz  = v && run && alu && ((m & last_wr) != '0);
    rdy  = run && (!out_pending || ordy) && !haz;
    xfer = v && rdy;
    check("in_ready", in_ready, rdy);
    check("out_valid", out_valid, out_pending);
    check("core_rstn", core_rstn, !(hold_left > 0 || fresh));
    check("err_sticky", err_sticky, sticky);
    fresh = 1'b0;
    if (hold_left > 0) hold_left--;
    if (stall_left > 0) stall_left = 0;
    else if (haz) begin
      stall_left = 1;
      last_wr    = '0;
    end
    if (xfer) begin
      if (op == OP_RST) begin
        hold_left   = RST_LEN;
        last_wr     = '0;
        out_pending = 1'b0;
      end else begin
        exp_q.push_back(expect_beat(w));
        out_pending = 1'b1;
        if (op == OP_LD || op == OP_ST) last_wr = m;
        else if ($countones(m) > 1) sticky = 1'b1;
      end
    end else if (out_pending && ordy) begin
      out_pending = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rstn && out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: actual=beat present required=none at %0t", $time);
      end else begin
        check("beat", {load_en, store_en, reg_ce, reg_oe, instr_code, imm, illegal}, exp_q[0]);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [3:0] op;
    logic [NREGS-1:0] m;
    int r;

    model_reset();
    #12;
    check_reset_values();
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // LD followed by a dependent ALU op: hazard cycle, one STALL cycle, then acceptance.
    step(1'b1, mk(OP_LD, 4'b0010, 8'hA5), 1'b1);
    in_valid  = 1'b1;
    cell_data = mk(4'h5, 4'b0010, 8'h11);
    out_ready = 1'b1;
    #2;
    check("hazard_bubble_on", in_ready, 1'b0);
    check("hazard_bubble_off", nh_in_ready, 1'b1);
    repeat (3) step(1'b1, mk(4'h5, 4'b0010, 8'h11), 1'b1);

    // RST: core reset held, LD waiting on the input is taken once the hold ends.
    step(1'b1, mk(OP_RST, 4'b0000, 8'h00), 1'b1);
    repeat (RST_LEN + 1) step(1'b1, mk(OP_LD, 4'b0100, 8'h3C), 1'b1);

    // Illegal multi-hot ALU op, then an LD/ST NOP with an empty mask.
    step(1'b1, mk(4'h7, 4'b0110, 8'h5A), 1'b1);
    step(1'b1, mk(OP_ST, 4'b0000, 8'h01), 1'b1);

    // Output backpressure for three cycles with the next instruction waiting.
    step(1'b1, mk(OP_ST, 4'b1000, 8'hC3), 1'b0);
    repeat (3) step(1'b1, mk(4'h9, 4'b0001, 8'h77), 1'b0);
    step(1'b1, mk(4'h9, 4'b0001, 8'h77), 1'b1);
    step(1'b0, '0, 1'b1);

    // RST blocked by a pending beat, then rstn pulse in the middle of the hold.
    step(1'b1, mk(OP_LD, 4'b0001, 8'h10), 1'b0);
    step(1'b1, mk(OP_RST, 4'b0000, 8'h00), 1'b0);
    step(1'b1, mk(OP_RST, 4'b0000, 8'h00), 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    rstn = 1'b0;
    #2;
    check_reset_values();
    model_reset();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    step(1'b1, mk(OP_LD, 4'b0010, 8'hA5), 1'b1);
    step(1'b0, '0, 1'b1);

    for (int n = 0; n < 1500; n++) begin
      r = $urandom_range(0, 19);
      if (r == 0)       op = OP_RST;
      else if (r <= 6)  op = OP_LD;
      else if (r <= 12) op = OP_ST;
      else              op = 4'($urandom_range(3, 15));
      r = $urandom_range(0, 3);
      if (r == 0)      m = '0;
      else if (r <= 2) m = NREGS'(1) << $urandom_range(0, NREGS - 1);
      else             m = NREGS'($urandom);
      step($urandom_range(0, 3) != 0, mk(op, m, DATA_W'($urandom)), $urandom_range(0, 3) != 0);
    end

    repeat (RST_LEN + 3) step(1'b0, '0, 1'b1);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_decode_unit.md
INSTR_DECODE_UNIT -- requirements
Module: instr_decode_unit

Interface
REQ-001 Parameter DATA_W, default 8, immediate field width.
REQ-002 Parameter NREGS, default 4, register count; the register mask is one-hot, NREGS bits.
REQ-003 Parameter RST_LEN, default 4, core reset hold length in cycles; legal range 1..255.
REQ-004 Parameter HAZARD_STALL, default 1: 1 enables the read-after-write stall, 0 disables it.
REQ-005 Derived INSTR_W = NREGS+4+DATA_W; fields: mask [INSTR_W-1:DATA_W+4], opcode [DATA_W+3:DATA_W], imm [DATA_W-1:0].
REQ-006 clk  in  1  single clock, rising edge.
REQ-007 rstn  in  1  asynchronous, active-low reset.
REQ-008 in_valid / in_ready  in / out  1 / 1  instruction handshake.
REQ-009 cell_data  in  INSTR_W  instruction word.
REQ-010 out_valid / out_ready  out / in  1 / 1  decoded-output handshake.
REQ-011 core_rstn  out  1  datapath reset, active-low.
REQ-012 load_en, store_en  out  1 each  LD / ST strobes.
REQ-013 reg_ce, reg_oe  out  NREGS each  register write / read enables.
REQ-014 instr_code  out  4  registered opcode; imm  out  DATA_W  registered immediate.
REQ-015 illegal  out  1  current output is a squashed illegal instruction; err_sticky  out  1  latched illegal flag.

Function
REQ-016 Opcodes RST, LD, ST use the team's shared instruction-definition encodings; every other opcode is an ALU op.
REQ-017 FSM states: RUN, RST_HOLD, STALL.
REQ-018 in_ready = (state==RUN) && (!out_valid || out_ready) && !hazard; the transfer occurs on in_valid && in_ready.
REQ-019 Output registers load on the transfer cycle; out_valid rises on the next edge, giving 1-cycle latency.
REQ-020 Output registers hold stable while out_valid && !out_ready.
REQ-021 out_valid clears when the output is consumed and no new transfer occurs in the same cycle.
REQ-022 LD: load_en=1, store_en=0, reg_ce=mask, reg_oe=0.
REQ-023 ST: store_en=1, load_en=0, reg_ce=mask, reg_oe=0.
REQ-024 ALU op: load_en=store_en=0, reg_ce=0, reg_oe=mask.
REQ-025 An ALU op whose mask has more than one bit set is illegal.
REQ-026 An illegal instruction is accepted and output with all enables 0, illegal=1, and sets err_sticky.
REQ-027 An LD/ST with mask 0 is a legal NOP: out_valid=1 with all enables 0.
REQ-028 Accepted RST: no output beat is produced; out_valid clears; state goes to RST_HOLD.
REQ-029 In RST_HOLD, core_rstn=0 for exactly RST_LEN cycles, counted by an internal counter, and in_ready=0; the state then returns to RUN with core_rstn=1.
REQ-030 last_wr_mask records reg_ce of every accepted LD/ST and is cleared by an accepted RST.
REQ-031 hazard = HAZARD_STALL && in_valid && state==RUN && opcode is an ALU op && (mask & last_wr_mask)!=0.
REQ-032 On hazard the unit goes RUN->STALL for 1 cycle with in_ready=0, clears last_wr_mask, then returns to RUN.
REQ-033 With HAZARD_STALL=0, hazard is constant 0 and the unit never enters STALL.
REQ-034 A pending output with out_ready=0 blocks acceptance of RST; RST takes effect only once the output slot is free.
REQ-035 in_valid deasserting during STALL returns the unit to RUN without an output beat.
REQ-036 An output-side stall during STALL does not extend the STALL state itself.

Reset
REQ-037 While rstn=0: state=RUN, out_valid=0, core_rstn=0, all enables 0, instr_code=0, imm=0, illegal=0, err_sticky=0, last_wr_mask=0, counter=0.
REQ-038 core_rstn rises on the first clk edge after rstn deasserts.
REQ-039 rstn assertion during RST_HOLD or STALL aborts that state immediately.
REQ-040 err_sticky clears only via rstn.

Verification
REQ-041 LD with mask 4'b0010, imm 8'hA5, out_ready=1 -> next cycle out_valid=1, load_en=1, reg_ce=4'b0010, imm=8'hA5.
REQ-042 ALU op mask 4'b0010 directly after the LD above, HAZARD_STALL=1 -> in_ready=0 for 1 cycle, accepted in the following cycle, reg_oe=4'b0010; with HAZARD_STALL=0 -> no bubble.
REQ-043 RST with RST_LEN=4 -> core_rstn=0 for exactly 4 cycles, no out_valid, in_ready=0 throughout, then RUN.
REQ-044 ALU op mask 4'b0110 -> out_valid=1, illegal=1, all enables 0, err_sticky=1 until rstn.
REQ-045 out_ready=0 for 3 cycles with the next instruction valid -> outputs stable, in_ready=0, no instruction lost or duplicated.
REQ-046 rstn pulse mid-RST_HOLD -> all outputs at reset values; normal LD accepted after release.
